// File: rtl/dac_threshold_spi.sv
// SPI DAC threshold writer: takes a 16-bit code on a one-cycle strobe, shifts it to the DAC,
// waits for the analog output to settle, then raises ready. Writes arriving while busy coalesce.
module dac_threshold_spi #(
    parameter int          CLK_DIV       = 2,
    parameter int          SETTLE_CYCLES = 10,
    parameter logic [3:0]  DAC_CMD       = 4'b0011,
    parameter logic [15:0] INIT_CODE     = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] threshold_i,
    input  logic        threshold_wre_i,
    output logic        threshold_rdy_o,
    output logic [15:0] last_code_o,
    output logic        dac_sclk_o,
    output logic        dac_mosi_o,
    output logic        dac_cs_n_o
);

    localparam int CMAX = (CLK_DIV > SETTLE_CYCLES) ? CLK_DIV : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_SETTLE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_bit;
    logic          r_hi;
    logic [23:0]   r_sr;
    logic [15:0]   r_fcode;
    logic          r_pend;
    logic [15:0]   r_pcode;
    logic          r_boot;
    logic          r_rdy;
    logic [15:0]   r_last;
    logic          r_sclk;
    logic          r_csn;

    logic          w_wr;
    logic [15:0]   w_wcode;
    logic          w_done;
    logic          w_take;
    logic [15:0]   w_ncode;
    logic [23:0]   w_frame;

    // The first cycle out of reset acts as a write of INIT_CODE; a real strobe on that edge wins.
    assign w_wr    = threshold_wre_i | r_boot;
    assign w_wcode = threshold_wre_i ? threshold_i : INIT_CODE;
    assign w_done  = (r_cnt == '0);
    // A new frame starts from IDLE one cycle after the write is latched, or straight out of
    // the last SETTLE cycle when anything is waiting (including a strobe on that very edge).
    assign w_take  = ((r_state == S_IDLE) && r_pend) ||
                     ((r_state == S_SETTLE) && w_done && (r_pend || w_wr));
    assign w_ncode = w_wr ? w_wcode : r_pcode;
    assign w_frame = {DAC_CMD, w_ncode, 4'b0000};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_hi    <= 1'b0;
            r_sr    <= '0;
            r_fcode <= '0;
            r_pend  <= 1'b0;
            r_pcode <= '0;
            r_boot  <= 1'b1;
            r_rdy   <= 1'b0;
            r_last  <= '0;
            r_sclk  <= 1'b0;
            r_csn   <= 1'b1;
        end else begin
            r_boot <= 1'b0;

            if (w_take) begin
                r_pend <= 1'b0;
            end else if (w_wr) begin
                r_pend  <= 1'b1;
                r_pcode <= w_wcode;
            end

            if (w_take) begin
                r_state <= S_CS_SETUP;
                r_sr    <= w_frame;
                r_fcode <= w_ncode;
                r_cnt   <= DIV_LD;
                r_csn   <= 1'b0;
                r_sclk  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_CS_SETUP: begin
                        if (w_done) begin
                            r_state <= S_SHIFT;
                            r_hi    <= 1'b1;
                            r_sclk  <= 1'b1;
                            r_bit   <= 5'd23;
                            r_cnt   <= DIV_LD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (!w_done) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (r_hi) begin
                            r_sclk <= 1'b0;
                            r_hi   <= 1'b0;
                            r_cnt  <= DIV_LD;
                        end else if (r_bit == 5'd0) begin
                            r_state <= S_CS_HOLD;
                            r_cnt   <= DIV_LD;
                        end else begin
                            // next bit appears on mosi together with the rising sclk
                            r_sr   <= {r_sr[22:0], 1'b0};
                            r_sclk <= 1'b1;
                            r_hi   <= 1'b1;
                            r_bit  <= r_bit - 1'b1;
                            r_cnt  <= DIV_LD;
                        end
                    end
                    S_CS_HOLD: begin
                        if (w_done) begin
                            r_state <= S_SETTLE;
                            r_csn   <= 1'b1;
                            r_sr    <= '0;
                            r_last  <= r_fcode;
                            r_cnt   <= SET_LD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (w_done) begin
                            r_state <= S_IDLE;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_wr) r_rdy <= 1'b0;
        end
    end

    assign threshold_rdy_o = r_rdy;
    assign last_code_o     = r_last;
    assign dac_sclk_o      = r_sclk;
    assign dac_mosi_o      = r_sr[23];
    assign dac_cs_n_o      = r_csn;

endmodule

// File: tb/tb_dac_threshold_spi.sv
// Directed and randomized checks of dac_threshold_spi against frame/latency rules
// computed in the bench; a second instance runs with the fastest timing parameters.
module tb_dac_threshold_spi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] thr = '0;
    logic        wre = 1'b0;
    logic        wre_f = 1'b0;
    logic        rdy, sclk, mosi, csn;
    logic [15:0] last;
    logic        rdy_f, sclk_f, mosi_f, csn_f;
    logic [15:0] last_f;

    localparam int D  = 2;
    localparam int S  = 10;
    localparam int DF = 1;
    localparam int SF = 1;

    dac_threshold_spi dut (
        .clk_i(clk), .rst_i(rst), .threshold_i(thr), .threshold_wre_i(wre),
        .threshold_rdy_o(rdy), .last_code_o(last), .dac_sclk_o(sclk),
        .dac_mosi_o(mosi), .dac_cs_n_o(csn)
    );

    dac_threshold_spi #(.CLK_DIV(DF), .SETTLE_CYCLES(SF)) dut_f (
        .clk_i(clk), .rst_i(rst), .threshold_i(thr), .threshold_wre_i(wre_f),
        .threshold_rdy_o(rdy_f), .last_code_o(last_f), .dac_sclk_o(sclk_f),
        .dac_mosi_o(mosi_f), .dac_cs_n_o(csn_f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference rules
    function automatic logic [23:0] fr(input logic [15:0] c);
        return {4'b0011, c, 4'b0000};
    endfunction
    function automatic int lat_one(input int d, input int s);
        return 1 + 50 * d + s;
    endfunction

    // SPI receiver model: samples mosi on falling sclk while cs_n is low
    logic [23:0] mon_sr = '0;
    int          mon_bits = 0;
    logic [23:0] frames[$];
    int          lo_q[$];
    int          hi_q[$];
    int          lo_len = 0, hi_len = 0;
    logic        prev_cs = 1'b1;

    always @(negedge sclk) begin
        if (!csn) begin
            mon_sr = {mon_sr[22:0], mosi};
            mon_bits++;
        end
    end

    always @(negedge clk) begin
        if (csn && !prev_cs) begin
            if (mon_bits == 24) frames.push_back(mon_sr);
            lo_q.push_back(lo_len);
            lo_len = 0; hi_len = 0; mon_bits = 0;
        end
        if (!csn && prev_cs) begin
            hi_q.push_back(hi_len);
            lo_len = 0; mon_bits = 0;
        end
        if (csn) hi_len++; else lo_len++;
        prev_cs = csn;
    end

    function automatic logic [31:0] frame_at(input int i);
        if (i < frames.size()) return {8'h00, frames[i]};
        return 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] hi_at(input int i);
        if (i < hi_q.size()) return 32'(hi_q[i]);
        return 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] lo_last();
        if (lo_q.size() > 0) return 32'(lo_q[lo_q.size()-1]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input bit f, input logic [15:0] code, output int n0);
        @(negedge clk);
        thr = code;
        if (f) wre_f = 1'b1; else wre = 1'b1;
        @(negedge clk);
        wre = 1'b0; wre_f = 1'b0;
        n0 = cyc;
    endtask

    task automatic wait_rdy(input bit f, input int n0, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if ((f ? rdy_f : rdy) === 1'b1) begin
                lat = cyc - n0;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, lat, nw, gap;
        logic [15:0] code, expect_code;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy",  32'(rdy),  32'd0);
        chk("rst_cs_n", 32'(csn),  32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        n0 = cyc;
        chk("boot_rdy_low", 32'(rdy), 32'd0);
        wait_rdy(0, n0, lat);
        chk("boot_lat",    32'(lat), 32'(lat_one(D, S)));
        chk("boot_nframe", 32'(frames.size()), 32'd1);
        chk("boot_frame",  frame_at(0), 32'h0030_0000);
        chk("boot_last",   32'(last), 32'd0);

        // Single write from IDLE
        frames.delete(); lo_q.delete();
        strobe(0, 16'hA5C3, n0);
        chk("wr_rdy_clr", 32'(rdy), 32'd0);
        repeat (100) @(negedge clk);
        chk("wr_hold_cs",   32'(csn),  32'd0);
        chk("wr_hold_last", 32'(last), 32'd0);
        @(negedge clk);
        chk("wr_exit_cs",   32'(csn),  32'd1);
        chk("wr_exit_last", 32'(last), 32'h0000_A5C3);
        wait_rdy(0, n0, lat);
        chk("wr_lat",    32'(lat), 32'(lat_one(D, S)));
        chk("wr_frame",  frame_at(0), {8'h00, fr(16'hA5C3)});
        chk("wr_cs_low", lo_last(), 32'(50 * D));

        // Writes while busy coalesce, last write wins
        frames.delete();
        strobe(0, 16'h0001, n0);
        repeat (20) @(negedge clk);
        strobe(0, 16'h0002, n1);
        strobe(0, 16'h0003, n1);
        wait_rdy(0, n0, lat);
        chk("pend_lat",    32'(lat), 32'(lat_one(D, S) + 50 * D + S));
        chk("pend_nframe", 32'(frames.size()), 32'd2);
        chk("pend_frame0", frame_at(0), {8'h00, fr(16'h0001)});
        chk("pend_frame1", frame_at(1), {8'h00, fr(16'h0003)});
        chk("pend_last",   32'(last), 32'h0000_0003);

        // Strobe on the last SETTLE cycle chains without an IDLE cycle
        frames.delete(); hi_q.delete();
        code = 16'($urandom);
        strobe(0, code, n0);
        repeat (lat_one(D, S) - 2) @(negedge clk);
        chk("chain_pre_rdy", 32'(rdy), 32'd0);
        strobe(0, 16'hFFFF, n1);
        chk("chain_edge", 32'(n1 - n0), 32'(lat_one(D, S)));
        wait_rdy(0, n1, lat);
        chk("chain_lat",    32'(lat), 32'(50 * D + S));
        chk("chain_frame0", frame_at(0), {8'h00, fr(code)});
        chk("chain_frame1", frame_at(1), 32'h003F_FFF0);
        chk("chain_cs_gap", hi_at(1), 32'(S));

        // Reset in the middle of bit 12
        code = 16'($urandom);
        strobe(0, code, n0);
        repeat (1 + D + (23 - 12) * 2 * D + D - 1) @(negedge clk);
        chk("mid_cs_low", 32'(csn), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cs_n", 32'(csn),  32'd1);
        chk("mrst_sclk", 32'(sclk), 32'd0);
        chk("mrst_mosi", 32'(mosi), 32'd0);
        chk("mrst_rdy",  32'(rdy),  32'd0);
        rst = 1'b0;
        frames.delete();
        @(negedge clk);
        n0 = cyc;
        wait_rdy(0, n0, lat);
        chk("mrst_lat",    32'(lat), 32'(lat_one(D, S)));
        chk("mrst_nframe", 32'(frames.size()), 32'd1);
        chk("mrst_frame",  frame_at(0), 32'h0030_0000);

        // Randomized write bursts: the latest code is always the one that lands
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(1, 3);
            expect_code = '0;
            for (int k = 0; k < nw; k++) begin
                gap = $urandom_range(0, 120);
                repeat (gap) @(negedge clk);
                expect_code = 16'($urandom);
                strobe(0, expect_code, n0);
            end
            wait_rdy(0, n0, lat);
            chk("rnd_timeout", 32'(lat < 0), 32'd0);
            chk("rnd_last",    32'(last), {16'h0, expect_code});
            chk("rnd_frame",   (frames.size() > 0) ? {8'h00, frames[frames.size()-1]} : 32'hDEAD_BEEF,
                {8'h00, fr(expect_code)});
        end

        // Fastest timing instance
        code = 16'($urandom);
        strobe(1, code, n0);
        for (int i = 0; i < 20; i++) begin
            if (sclk_f === 1'b1) break;
            @(negedge clk);
        end
        chk("fast_first_hi", 32'(cyc - n0), 32'd2);
        @(negedge clk);
        chk("fast_lo", 32'(sclk_f), 32'd0);
        @(negedge clk);
        chk("fast_hi", 32'(sclk_f), 32'd1);
        wait_rdy(1, n0, lat);
        chk("fast_lat",  32'(lat), 32'(lat_one(DF, SF)));
        chk("fast_last", 32'(last_f), {16'h0, code});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
